// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Steps an instruction through NUM_STAGES sequential stages, one active stage
// at a time. Stage XF_STAGE can insert one extra fetch cycle (XFETCH), which
// reuses stage 0's hardware.
// Optional macro SEQ_PERF_CNT_EN adds retire and cycle performance counters.
// Without it, both counters are tied to zero.
module multicycle_sequencer #(
   parameter int NUM_STAGES = 5,
   parameter int XF_STAGE   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  halt,
   input  logic                  flush,
   input  logic [NUM_STAGES-1:0] stall,
   input  logic                  ext_fetch,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic [NUM_STAGES-1:0] latch_en,
   output logic                  xfetch,
   output logic                  instr_done,
   output logic                  busy,
   output logic                  idle,
   output logic [CNT_W-1:0]      retire_cnt,
   output logic [CNT_W-1:0]      cycle_cnt
);

   // State encoding: RUN(k) is encoded as k. IDLE and XFETCH use codes that
   // sit above any legal stage index (NUM_STAGES is at most 8).
   localparam logic [3:0] S_IDLE  = 4'd15;
   localparam logic [3:0] S_XF    = 4'd14;
   localparam logic [3:0] S_LAST  = 4'(NUM_STAGES - 1);
   localparam logic [3:0] S_XFSTG = 4'(XF_STAGE);
   localparam logic [3:0] S_AFTER = 4'(XF_STAGE + 1);

   logic [3:0]            state_q, state_d;
   logic                  halt_q, halt_d;
   logic [NUM_STAGES-1:0] run_vec;
   logic                  in_idle, in_xf, act_stall, halt_eff;

   // One-hot decode of RUN(k) straight from the state register.
   generate
      for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_run
         assign run_vec[gi] = (state_q == 4'(gi));
      end
   endgenerate

   assign in_idle   = (state_q == S_IDLE);
   assign in_xf     = (state_q == S_XF);
   // Only the active stage's stall bit is honoured. XFETCH borrows stage 0.
   assign act_stall = in_xf ? stall[0] : |(run_vec & stall);
   // A halt raised in the same cycle counts as already pending.
   assign halt_eff  = halt_q | halt;

   // State and pending-halt registers. Reset is asynchronous.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         halt_q  <= halt_d;
      end
   end

   // Next-state logic. Priority order: flush, then stall, then advance.
   always_comb begin
      state_d = state_q;
      halt_d  = halt_q;
      if (in_idle) begin
         if (start && !halt) state_d = 4'd0;
      end else if (flush) begin
         state_d = halt_eff ? S_IDLE : 4'd0;
      end else if (act_stall) begin
         state_d = state_q;
      end else if (in_xf) begin
         state_d = S_AFTER;
      end else if (state_q == S_XFSTG && ext_fetch) begin
         state_d = S_XF;
      end else if (state_q == S_LAST) begin
         state_d = halt_eff ? S_IDLE : 4'd0;
      end else begin
         state_d = state_q + 4'd1;
      end
      // Pending halt is cleared on entering IDLE.
      // Otherwise it is set by any halt seen while busy.
      if (state_d == S_IDLE)
         halt_d = 1'b0;
      else if (!in_idle && halt)
         halt_d = 1'b1;
   end

   // Output decode. The Moore outputs depend on state only.
   // latch_en and instr_done also depend on stall and flush.
   always_comb begin
      stage_en    = run_vec;
      stage_en[0] = run_vec[0] | in_xf;
      xfetch      = in_xf;
      idle        = in_idle;
      busy        = ~in_idle;
      latch_en    = '0;
      if (!flush) begin
         latch_en = run_vec & ~stall;
         if (in_xf && !stall[0]) latch_en[0] = 1'b1;
      end
      instr_done  = !flush && (state_q == S_LAST) && !stall[NUM_STAGES-1];
   end

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] retire_q, cycle_q;

   // Performance counters. They wrap freely and are frozen while IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_q <= '0;
         cycle_q  <= '0;
      end else begin
         if (!in_idle)   cycle_q  <= cycle_q + 1'b1;
         if (instr_done) retire_q <= retire_q + 1'b1;
      end
   end

   assign retire_cnt = retire_q;
   assign cycle_cnt  = cycle_q;
`else
   assign retire_cnt = '0;
   assign cycle_cnt  = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer (NUM_STAGES=5, XF_STAGE=1, CNT_W=4).
// Each call to cyc applies one cycle of inputs, checks every output against the
// hand-written expected values, and then advances one clock.
module tb_multicycle_sequencer;

   localparam int NS = 5;
`ifdef SEQ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, start, halt, flush, ext_fetch;
   logic [NS-1:0] stall;
   logic [NS-1:0] stage_en, latch_en;
   logic          xfetch, instr_done, busy, idle;
   logic [3:0]    retire_cnt, cycle_cnt;

   int errors = 0;
   int checks = 0;
   int ncyc   = 0;
   logic [3:0] m_ret = 4'd0;
   logic [3:0] m_cyc = 4'd0;

   always #5 clk = ~clk;

   multicycle_sequencer #(.NUM_STAGES(NS), .XF_STAGE(1), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .flush(flush),
      .stall(stall), .ext_fetch(ext_fetch), .stage_en(stage_en),
      .latch_en(latch_en), .xfetch(xfetch), .instr_done(instr_done),
      .busy(busy), .idle(idle), .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL cyc%0d %s: got %0h expected %0h", ncyc, tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outs();
      chk("rst.stage_en", 32'(stage_en), 32'd0);
      chk("rst.latch_en", 32'(latch_en), 32'd0);
      chk("rst.xfetch", 32'(xfetch), 32'd0);
      chk("rst.instr_done", 32'(instr_done), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.idle", 32'(idle), 32'd1);
      chk("rst.retire_cnt", 32'(retire_cnt), 32'd0);
      chk("rst.cycle_cnt", 32'(cycle_cnt), 32'd0);
   endtask

   // One cycle: drive the inputs, check the outputs, update the counter model,
   // then advance the clock.
   task automatic cyc(input logic st, input logic hl, input logic fl,
                      input logic [NS-1:0] sl, input logic ex,
                      input logic [NS-1:0] e_stg, input logic [NS-1:0] e_lat,
                      input logic e_xf, input logic e_done, input logic e_idle);
      start = st; halt = hl; flush = fl; stall = sl; ext_fetch = ex;
      #1;
      $display("cyc%0d st=%b hl=%b fl=%b stall=%b ex=%b -> stage_en=%b latch_en=%b xf=%b done=%b idle=%b rc=%0d cc=%0d",
               ncyc, st, hl, fl, sl, ex, stage_en, latch_en, xfetch, instr_done, idle, retire_cnt, cycle_cnt);
      chk("stage_en", 32'(stage_en), 32'(e_stg));
      chk("latch_en", 32'(latch_en), 32'(e_lat));
      chk("xfetch", 32'(xfetch), 32'(e_xf));
      chk("instr_done", 32'(instr_done), 32'(e_done));
      chk("idle", 32'(idle), 32'(e_idle));
      chk("busy", 32'(busy), 32'(!e_idle));
      chk("retire_cnt", 32'(retire_cnt), PERF ? 32'(m_ret) : 32'd0);
      chk("cycle_cnt", 32'(cycle_cnt), PERF ? 32'(m_cyc) : 32'd0);
      if (e_done) m_ret = m_ret + 4'd1;
      if (!e_idle) m_cyc = m_cyc + 4'd1;
      ncyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; halt = 1'b0; flush = 1'b0; stall = '0; ext_fetch = 1'b0;
      #1;
      chk_reset_outs();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Plain instruction, then the next one starts back at RUN(0).
      cyc(1, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00001, 5'b00001, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00010, 5'b00010, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00100, 5'b00100, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b01000, 5'b01000, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b10000, 5'b10000, 0, 1, 0);
      // Stall stage 2 for three cycles; stall bits of inactive stages are ignored.
      cyc(0, 0, 0, 5'b11110, 0, 5'b00001, 5'b00001, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00010, 5'b00010, 0, 0, 0);
      cyc(0, 0, 0, 5'b00100, 0, 5'b00100, 5'b00000, 0, 0, 0);
      cyc(0, 0, 0, 5'b00100, 0, 5'b00100, 5'b00000, 0, 0, 0);
      cyc(0, 0, 0, 5'b00100, 0, 5'b00100, 5'b00000, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00100, 5'b00100, 0, 0, 0);
      cyc(0, 0, 0, 5'b00100, 0, 5'b01000, 5'b01000, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b10000, 5'b10000, 0, 1, 0);
      // Extra fetch after stage 1. ext_fetch is ignored in RUN(0) and RUN(2).
      cyc(0, 0, 0, 5'b00000, 1, 5'b00001, 5'b00001, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 1, 5'b00010, 5'b00010, 0, 0, 0);
      cyc(0, 0, 0, 5'b00001, 1, 5'b00001, 5'b00000, 1, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00001, 5'b00001, 1, 0, 0);
      cyc(0, 0, 0, 5'b00000, 1, 5'b00100, 5'b00100, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b01000, 5'b01000, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b10000, 5'b10000, 0, 1, 0);
      // Halt pulse in RUN(1): the instruction finishes, then the sequencer goes IDLE.
      cyc(0, 0, 0, 5'b00000, 0, 5'b00001, 5'b00001, 0, 0, 0);
      cyc(0, 1, 0, 5'b00000, 0, 5'b00010, 5'b00010, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00100, 5'b00100, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b01000, 5'b01000, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b10000, 5'b10000, 0, 1, 0);
      cyc(1, 1, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1);
      cyc(1, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1);
      // Flush in RUN(3) restarts at RUN(0). A flush with halt pending goes to IDLE.
      cyc(0, 0, 0, 5'b00000, 0, 5'b00001, 5'b00001, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00010, 5'b00010, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00100, 5'b00100, 0, 0, 0);
      cyc(0, 0, 1, 5'b00000, 0, 5'b01000, 5'b00000, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00001, 5'b00001, 0, 0, 0);
      cyc(0, 1, 0, 5'b00000, 0, 5'b00010, 5'b00010, 0, 0, 0);
      cyc(0, 0, 1, 5'b00000, 0, 5'b00100, 5'b00000, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1);
      // Reset in the middle of RUN(2). start is needed again to leave IDLE.
      cyc(1, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00001, 5'b00001, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00010, 5'b00010, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outs();
      m_ret = 4'd0; m_cyc = 4'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1);
      // 17 unstalled instructions (85 cycles) to make the 4-bit counters wrap.
      cyc(1, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1);
      for (int k = 0; k < 85; k++) begin
         cyc(0, 0, 0, 5'b00000, 0, 5'(1 << (k % 5)), 5'(1 << (k % 5)), 0, (k % 5) == 4, 0);
      end
      chk("wrap.retire_cnt", 32'(retire_cnt), PERF ? 32'd1 : 32'd0);
      chk("wrap.cycle_cnt", 32'(cycle_cnt), PERF ? 32'd5 : 32'd0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00001, 5'b00001, 0, 0, 0);
      cyc(0, 0, 0, 5'b00000, 0, 5'b00010, 5'b00010, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outs();
      @(posedge clk); #1;
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
